// File: rtl/register_file_nxm.sv
// Dual-read / single-write register file with registered reads, write-to-read bypass,
// optional hard-wired zero register and a per-register pending (scoreboard) bit.
module register_file_nxm #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr_r1,
  input  logic [ADDR_WIDTH-1:0] addr_r2,
  output logic [DATA_WIDTH-1:0] data_r1,
  output logic [DATA_WIDTH-1:0] data_r2,
  output logic                  busy_r1,
  output logic                  busy_r2,
  output logic                  rd_valid,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] data_w,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic [ADDR_WIDTH:0]   pend_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic        ZR    = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [DEPTH-1:0]      pend_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  wr_ok;
  logic                  rsv_ok;
  logic [DATA_WIDTH-1:0] rd1_data;
  logic [DATA_WIDTH-1:0] rd2_data;
  logic                  rd1_busy;
  logic                  rd2_busy;

  // Accepted write/reserve; address 0 is inert when it is the zero register.
  always_comb begin
    wr_ok  = we && !(ZR && (addr_w == '0));
    rsv_ok = rsv_en && !(ZR && (rsv_addr == '0));
  end

  // Next pending vector: a write completes a load, a same-cycle reservation wins.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok) begin
      pend_nxt[addr_w] = 1'b0;
    end
    if (rsv_ok) begin
      pend_nxt[rsv_addr] = 1'b1;
    end
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[i]);
    end
  end

  // Read port values with bypass; busy reflects this cycle's write/reserve at once.
  always_comb begin
    rd1_data = mem[addr_r1];
    rd1_busy = pend_nxt[addr_r1];
    if (wr_ok && (addr_w == addr_r1)) begin
      rd1_data = data_w;
    end
    if (ZR && (addr_r1 == '0)) begin
      rd1_data = '0;
      rd1_busy = 1'b0;
    end

    rd2_data = mem[addr_r2];
    rd2_busy = pend_nxt[addr_r2];
    if (wr_ok && (addr_w == addr_r2)) begin
      rd2_data = data_w;
    end
    if (ZR && (addr_r2 == '0)) begin
      rd2_data = '0;
      rd2_busy = 1'b0;
    end
  end

  // Register array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[addr_w] <= data_w;
    end
  end

  // Scoreboard and its population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  // Registered read outputs; data and busy hold while rd_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r1  <= '0;
      data_r2  <= '0;
      busy_r1  <= 1'b0;
      busy_r2  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        data_r1 <= rd1_data;
        data_r2 <= rd2_data;
        busy_r1 <= rd1_busy;
        busy_r2 <= rd2_busy;
      end
    end
  end

endmodule

// File: tb/tb_register_file_nxm.sv
// Directed table plus hand sequences on 32x32 instances (zero register on and off),
// and a randomized run of a 16-bit x 8 instance against a behavioural model.
module tb_register_file_nxm;

  logic clk;
  logic rst_n;

  // Shared stimulus for the two 32x32 instances
  logic        rd_en, we, rsv_en;
  logic [4:0]  addr_r1, addr_r2, addr_w, rsv_addr;
  logic [31:0] data_w;

  logic [31:0] z1_d1, z1_d2, z0_d1, z0_d2;
  logic        z1_b1, z1_b2, z1_v, z0_b1, z0_b2, z0_v;
  logic [5:0]  z1_cnt, z0_cnt;

  // Small instance stimulus/outputs
  logic        s_rd, s_we, s_rsv;
  logic [2:0]  s_a1, s_a2, s_aw, s_ra;
  logic [15:0] s_dw, s_d1, s_d2;
  logic        s_b1, s_b2, s_v;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  register_file_nxm #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) u_z1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .addr_r1(addr_r1), .addr_r2(addr_r2),
    .data_r1(z1_d1), .data_r2(z1_d2), .busy_r1(z1_b1), .busy_r2(z1_b2), .rd_valid(z1_v),
    .we(we), .addr_w(addr_w), .data_w(data_w), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_cnt(z1_cnt)
  );

  register_file_nxm #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) u_z0 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .addr_r1(addr_r1), .addr_r2(addr_r2),
    .data_r1(z0_d1), .data_r2(z0_d2), .busy_r1(z0_b1), .busy_r2(z0_b2), .rd_valid(z0_v),
    .we(we), .addr_w(addr_w), .data_w(data_w), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_cnt(z0_cnt)
  );

  register_file_nxm #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1)) u_s (
    .clk(clk), .rst_n(rst_n), .rd_en(s_rd), .addr_r1(s_a1), .addr_r2(s_a2),
    .data_r1(s_d1), .data_r2(s_d2), .busy_r1(s_b1), .busy_r2(s_b2), .rd_valid(s_v),
    .we(s_we), .addr_w(s_aw), .data_w(s_dw), .rsv_en(s_rsv), .rsv_addr(s_ra),
    .pend_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        we;
    logic [4:0]  aw;
    logic [31:0] dw;
    logic        rsv;
    logic [4:0]  ra;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        v;
    logic [5:0]  cnt;
    logic [31:0] z0_d1;
    logic        z0_b1;
    logic [5:0]  z0_cnt;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vec [NVEC];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 0; we = 0; rsv_en = 0;
    addr_r1 = '0; addr_r2 = '0; addr_w = '0; rsv_addr = '0; data_w = '0;
  endtask

  // Behavioural model for the small instance
  logic [15:0] m_mem [8];
  logic        m_pend [8];
  logic [15:0] e_d1, e_d2;
  logic        e_b1, e_b2, e_v;
  logic [3:0]  e_cnt;

  function automatic logic [15:0] m_data(input logic [2:0] a, input logic w,
                                         input logic [2:0] wa, input logic [15:0] wd);
    if (a == 3'd0) return 16'h0;
    if (w && wa == a) return wd;
    return m_mem[a];
  endfunction

  function automatic logic m_busy(input logic [2:0] a, input logic w, input logic [2:0] wa,
                                  input logic r, input logic [2:0] rra);
    if (a == 3'd0) return 1'b0;
    if (r && rra == a) return 1'b1;
    if (w && wa == a) return 1'b0;
    return m_pend[a];
  endfunction

  initial begin
    vec[0]  = '{1, 3, 31, 0, 0, 32'h0,        0, 0,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        0, 0};
    vec[1]  = '{1, 5, 31, 1, 5, 32'hDEADBEEF, 0, 0,  32'hDEADBEEF, 32'h0,        0, 0, 1, 0, 32'hDEADBEEF, 0, 0};
    vec[2]  = '{0, 0, 0,  0, 0, 32'h0,        0, 0,  32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
    vec[3]  = '{0, 0, 0,  0, 0, 32'h0,        1, 7,  32'hDEADBEEF, 32'h0,        0, 0, 0, 1, 32'hDEADBEEF, 0, 1};
    vec[4]  = '{1, 5, 7,  0, 0, 32'h0,        0, 0,  32'hDEADBEEF, 32'h0,        0, 1, 1, 1, 32'hDEADBEEF, 0, 1};
    vec[5]  = '{0, 0, 0,  1, 7, 32'h1234,     0, 0,  32'hDEADBEEF, 32'h0,        0, 1, 0, 0, 32'hDEADBEEF, 0, 0};
    vec[6]  = '{1, 3, 7,  0, 0, 32'h0,        0, 0,  32'h0,        32'h1234,     0, 0, 1, 0, 32'h0,        0, 0};
    vec[7]  = '{1, 9, 5,  1, 9, 32'h55,       1, 9,  32'h55,       32'hDEADBEEF, 1, 0, 1, 1, 32'h55,       1, 1};
    vec[8]  = '{1, 9, 9,  0, 0, 32'h0,        0, 0,  32'h55,       32'h55,       1, 1, 1, 1, 32'h55,       1, 1};
    vec[9]  = '{1, 12, 3, 0, 0, 32'h0,        1, 12, 32'h0,        32'h0,        1, 0, 1, 2, 32'h0,        1, 2};
    vec[10] = '{1, 20, 20, 1, 20, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 1, 2, 32'hA5A5A5A5, 0, 2};
    vec[11] = '{1, 12, 9, 0, 0, 32'h0,        1, 12, 32'h0,        32'h55,       1, 1, 1, 2, 32'h0,        1, 2};
    vec[12] = '{1, 12, 9, 1, 12, 32'h77,      1, 9,  32'h77,       32'h55,       0, 1, 1, 1, 32'h77,       0, 1};
    vec[13] = '{1, 0, 20, 1, 0, 32'hFFFFFFFF, 1, 0,  32'h0,        32'hA5A5A5A5, 0, 0, 1, 1, 32'hFFFFFFFF, 1, 2};
    vec[14] = '{1, 0, 9,  0, 0, 32'h0,        0, 0,  32'h0,        32'h55,       0, 1, 1, 1, 32'hFFFFFFFF, 1, 2};

    rst_n = 0;
    idle_inputs();
    s_rd = 0; s_we = 0; s_rsv = 0; s_a1 = '0; s_a2 = '0; s_aw = '0; s_ra = '0; s_dw = '0;
    repeat (2) step();
    chk("reset_z1", {z1_d1, z1_d2, z1_b1, z1_b2, z1_v, z1_cnt}, '0);
    chk("reset_z0", {z0_d1, z0_d2, z0_b1, z0_b2, z0_v, z0_cnt}, '0);
    #2 rst_n = 1;

    for (int i = 0; i < NVEC; i++) begin
      rd_en = vec[i].rd; addr_r1 = vec[i].a1; addr_r2 = vec[i].a2;
      we = vec[i].we; addr_w = vec[i].aw; data_w = vec[i].dw;
      rsv_en = vec[i].rsv; rsv_addr = vec[i].ra;
      step();
      chk($sformatf("v%0d_d1", i), z1_d1, vec[i].d1);
      chk($sformatf("v%0d_d2", i), z1_d2, vec[i].d2);
      chk($sformatf("v%0d_busy", i), {z1_b1, z1_b2}, {vec[i].b1, vec[i].b2});
      chk($sformatf("v%0d_valid", i), z1_v, vec[i].v);
      chk($sformatf("v%0d_cnt", i), z1_cnt, vec[i].cnt);
      chk($sformatf("v%0d_z0_d1", i), z0_d1, vec[i].z0_d1);
      chk($sformatf("v%0d_z0_b1", i), z0_b1, vec[i].z0_b1);
      chk($sformatf("v%0d_z0_cnt", i), z0_cnt, vec[i].z0_cnt);
    end

    // Reserve every register: full count without wrap, zero register excluded
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      rsv_en = 1; rsv_addr = 5'(i);
      step();
    end
    idle_inputs();
    chk("full_cnt_z0", z0_cnt, 6'd32);
    chk("full_cnt_z1", z1_cnt, 6'd31);
    rd_en = 1; addr_r1 = 0; addr_r2 = 31;
    step();
    chk("full_busy_z1", {z1_b1, z1_b2}, 2'b01);
    chk("full_busy_z0", {z0_b1, z0_b2}, 2'b11);

    // Asynchronous reset mid-operation
    rd_en = 1; addr_r1 = 5; rsv_en = 1; rsv_addr = 3;
    step();
    chk("pre_rst_d1", z1_d1, 32'hDEADBEEF);
    #2 rst_n = 0;
    idle_inputs();
    #1;
    chk("midrst_z1", {z1_d1, z1_d2, z1_b1, z1_b2, z1_v, z1_cnt}, '0);
    chk("midrst_z0", {z0_d1, z0_d2, z0_b1, z0_b2, z0_v, z0_cnt}, '0);
    step();
    #2 rst_n = 1;
    step();
    chk("post_rst_valid", z1_v, 1'b0);
    chk("post_rst_cnt", z0_cnt, 6'd0);
    rd_en = 1; addr_r1 = 5; addr_r2 = 9;
    step();
    chk("post_rst_read", {z0_d1, z0_d2, z0_b1, z0_b2, z0_v}, {32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
    idle_inputs();

    // Randomized run of the small instance against the model
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = '0;
      m_pend[i] = 1'b0;
    end
    e_d1 = '0; e_d2 = '0; e_b1 = 0; e_b2 = 0;
    for (int c = 0; c < 400; c++) begin
      s_rd = ($urandom_range(0, 9) < 7);
      s_we = ($urandom_range(0, 1) == 1);
      s_rsv = ($urandom_range(0, 9) < 3);
      s_a1 = 3'($urandom_range(0, 7)); s_a2 = 3'($urandom_range(0, 7));
      s_aw = 3'($urandom_range(0, 7)); s_ra = 3'($urandom_range(0, 7));
      s_dw = 16'($urandom);
      e_v = s_rd;
      if (s_rd) begin
        e_d1 = m_data(s_a1, s_we, s_aw, s_dw);
        e_d2 = m_data(s_a2, s_we, s_aw, s_dw);
        e_b1 = m_busy(s_a1, s_we, s_aw, s_rsv, s_ra);
        e_b2 = m_busy(s_a2, s_we, s_aw, s_rsv, s_ra);
      end
      if (s_we && s_aw != 3'd0) begin
        m_mem[s_aw] = s_dw;
        m_pend[s_aw] = 1'b0;
      end
      if (s_rsv && s_ra != 3'd0) m_pend[s_ra] = 1'b1;
      e_cnt = '0;
      for (int i = 0; i < 8; i++) e_cnt = e_cnt + 4'(m_pend[i]);
      step();
      chk($sformatf("rand%0d", c), {s_d1, s_d2, s_b1, s_b2, s_v, s_cnt},
          {e_d1, e_d2, e_b1, e_b2, e_v, e_cnt});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
